// File: rtl/scene_recovery_mac.sv
// Multi-channel scene-recovery MAC: J = clamp(A + (I - A) * inv_t), three-stage
// valid/ready pipeline with per-channel clamp flags and per-frame saturation count.
module scene_recovery_mac #(
   parameter int unsigned CHANNELS = 3,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned INT_W    = 2,
   parameter int unsigned FRAC_W   = 6,
   parameter int unsigned ROUND    = 1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic                           in_sof,
   input  logic [CHANNELS*(DATA_W+1)-1:0] in_diff,
   input  logic [CHANNELS*DATA_W-1:0]     in_atm,
   input  logic [INT_W+FRAC_W-1:0]        in_inv_t,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_sof,
   output logic [CHANNELS*DATA_W-1:0]     out_pix,
   output logic [CHANNELS-1:0]            out_sat,
   output logic [CNT_W-1:0]               sat_count
);

   localparam int unsigned INV_W  = INT_W + FRAC_W;
   localparam int unsigned DIFF_W = DATA_W + 1;
   localparam int unsigned PROD_W = DIFF_W + INV_W + 1;
   // two guard bits above the product so rounding and the atm add never wrap
   localparam int unsigned SUM_W  = PROD_W + 2;

   localparam logic signed [SUM_W-1:0] RND_ADD =
      (ROUND != 0 && FRAC_W > 0) ? SUM_W'(64'd1 << (FRAC_W - 1)) : '0;
   localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((64'd1 << DATA_W) - 64'd1);

   logic en;

   logic                           s1_valid;
   logic                           s1_sof;
   logic [CHANNELS*DIFF_W-1:0]     s1_diff;
   logic [CHANNELS*DATA_W-1:0]     s1_atm;
   logic [INV_W-1:0]               s1_inv;

   logic                           s2_valid;
   logic                           s2_sof;
   logic [CHANNELS*DATA_W-1:0]     s2_atm;
   logic [CHANNELS*PROD_W-1:0]     s2_prod;

   logic [CHANNELS*PROD_W-1:0]     prod_c;
   logic [CHANNELS*DATA_W-1:0]     pix_c;
   logic [CHANNELS-1:0]            sat_c;

   // whole pipeline advances together; a stalled output freezes bubbles too
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // per-channel multiply (S1->S2) and round/shift/add/clamp (S2->S3)
   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      logic signed [PROD_W-1:0] d_ext;
      logic signed [PROD_W-1:0] t_ext;
      logic signed [SUM_W-1:0]  p_ext;
      logic signed [SUM_W-1:0]  r_val;
      logic signed [SUM_W-1:0]  q_val;
      logic signed [SUM_W-1:0]  s_val;
      logic                     under;
      logic                     over;

      assign d_ext = PROD_W'($signed(s1_diff[k*DIFF_W +: DIFF_W]));
      assign t_ext = PROD_W'($signed({1'b0, s1_inv}));
      assign prod_c[k*PROD_W +: PROD_W] = d_ext * t_ext;

      assign p_ext = SUM_W'($signed(s2_prod[k*PROD_W +: PROD_W]));
      assign r_val = p_ext + RND_ADD;
      assign q_val = r_val >>> FRAC_W;
      assign s_val = q_val + SUM_W'($signed({1'b0, s2_atm[k*DATA_W +: DATA_W]}));
      assign under = s_val[SUM_W-1];
      assign over  = !under && (s_val > PIX_MAX);

      assign sat_c[k] = under || over;
      assign pix_c[k*DATA_W +: DATA_W] = under ? '0 :
                                         over  ? PIX_MAX[DATA_W-1:0] :
                                                 s_val[DATA_W-1:0];
   end

   // S1 input capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sof   <= 1'b0;
         s1_diff  <= '0;
         s1_atm   <= '0;
         s1_inv   <= '0;
      end else if (en) begin
         s1_valid <= in_valid;
         s1_sof   <= in_sof;
         s1_diff  <= in_diff;
         s1_atm   <= in_atm;
         s1_inv   <= in_inv_t;
      end
   end

   // S2 products
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_sof   <= 1'b0;
         s2_atm   <= '0;
         s2_prod  <= '0;
      end else if (en) begin
         s2_valid <= s1_valid;
         s2_sof   <= s1_sof;
         s2_atm   <= s1_atm;
         s2_prod  <= prod_c;
      end
   end

   // S3 output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_pix   <= '0;
         out_sat   <= '0;
      end else if (en) begin
         out_valid <= s2_valid;
         out_sof   <= s2_sof;
         out_pix   <= pix_c;
         out_sat   <= sat_c;
      end
   end

   // per-frame saturated-pixel count, restarted by the sof pixel, sticky at max
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count <= '0;
      end else if (out_valid && out_ready) begin
         if (out_sof) begin
            sat_count <= CNT_W'(|out_sat);
         end else if ((|out_sat) && (sat_count != {CNT_W{1'b1}})) begin
            sat_count <= sat_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/scene_recovery_mac.md
Name: scene_recovery_mac

Overview:
- Parametrised successor to the single-channel Q2.6 saturating multiplier in the scene-recovery datapath.
- Computes J = clamp(A + (I − A)·t⁻¹) for CHANNELS colour channels in parallel.
- Takes signed differences, per-channel atmospheric light and one shared inverse-transmission value; output is a recovered pixel per channel.
- 3-stage pipeline with valid/ready backpressure, selectable rounding, per-channel saturation flags and a per-frame saturation counter for tuning telemetry.

Parameters:
- CHANNELS, 3, number of colour channels processed in lockstep.
- DATA_W, 8, unsigned pixel and atmospheric-light width; difference width is DATA_W+1 (two's complement).
- INT_W, 2, integer bits of inverse transmission.
- FRAC_W, 6, fraction bits of inverse transmission; INV_W = INT_W+FRAC_W.
- ROUND, 1, 1 = round-half-up before truncation, 0 = truncate (floor).
- CNT_W, 16, width of sat_count.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept input this cycle.
- in_sof  in  1  start-of-frame marker, travels with the pixel.
- in_diff  in  CHANNELS*(DATA_W+1)  signed I−A per channel; channel k at [k*(DATA_W+1) +: DATA_W+1].
- in_atm  in  CHANNELS*DATA_W  unsigned A per channel.
- in_inv_t  in  INV_W  unsigned QINT_W.FRAC_W inverse transmission, shared by all channels.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts output.
- out_sof  out  1  delayed in_sof.
- out_pix  out  CHANNELS*DATA_W  recovered pixel per channel.
- out_sat  out  CHANNELS  per-channel clamp flag for out_pix.
- sat_count  out  CNT_W  saturated pixels in the current frame.

Behaviour:
- Reset (async, rst_n=0): every valid bit, out_valid, out_sof, out_pix, out_sat and sat_count = 0. All data registers clear.
- A reset asserted mid-stream discards all in-flight pixels. No output appears until new input arrives.
- Global enable: en = !out_valid || out_ready. in_ready = en, combinational.
- When en=0, all stages hold, including internal bubbles.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- S1 (on en): register in_diff, in_atm, in_inv_t, in_sof and valid.
- S2 (on en): p_k = signed(diff_k) × unsigned(inv_t), width DATA_W+1+INV_W+1, signed. Carry atm, sof and valid.
- S3 (on en):
  - q_k = (p_k + (ROUND ? 2^(FRAC_W−1) : 0)) >>> FRAC_W, arithmetic shift.
  - s_k = q_k + atm_k in wide signed arithmetic, no intermediate wrap.
  - If s_k < 0: out_pix_k = 0, out_sat_k = 1.
  - If s_k > 2^DATA_W−1: out_pix_k = 2^DATA_W−1, out_sat_k = 1.
  - Otherwise: out_pix_k = s_k, out_sat_k = 0.
- Latency: 3 cycles from input transfer to out_valid with out_ready held high. Throughput: 1 pixel/cycle.
- out_* hold stable while out_valid && !out_ready.
- sat_count, updated on output transfer only:
  - If out_sof: sat_count = (|out_sat) ? 1 : 0.
  - Else if |out_sat: increment, saturating at 2^CNT_W−1 (no wrap).
  - Otherwise: hold.
- Channels are fully independent except for the shared inv_t, sof and valid.
- in_inv_t = 0 yields out_pix = atm with out_sat = 0.

Test Plan:
- Defaults, out_ready=1; one channel with diff=+50, inv_t=0x60 (1.5), atm=100 → out_pix=175, out_sat=0, exactly 3 cycles after input transfer.
- Underflow: diff=−100, inv_t=0x80 (2.0), atm=150 → out_pix=0, out_sat=1. Overflow in another channel: diff=+120, inv_t=0xFF, atm=200 → 255, sat=1. A third channel: diff=0 → atm unchanged, sat=0.
- Rounding: diff=+1, inv_t=0x20, atm=0 → 1 with ROUND=1, 0 with ROUND=0. Also diff=−1, inv_t=0x20, ROUND=1 → q=0 → out_pix=atm.
- Backpressure: stream 6 distinct pixels with in_valid=1; drop out_ready for 4 cycles after the first output → in_ready=0 during the stall, out_* stable, all 6 emitted in order, none lost or duplicated.
- sat_count: frame of 5 pixels with 3 saturated → 3; next frame whose sof pixel saturates → 1. Preload the count to 2^CNT_W−1 (CNT_W=4, 20 saturated pixels) → holds at 15.
- Async reset mid-stream with 2 pixels in flight → outputs and sat_count 0 immediately, out_valid stays 0 until new input, then a fresh pixel emerges after 3 cycles.
